tff_updown_counter: RTL and testbench
=====================================

// Module: tff_updown_counter
// PURPOSE
//  WIDTH-bit register bank with toggle-flip-flop semantics, generalised into a
//  multi-mode counter: hold, per-bit toggle, count up, count down, and parallel load.
//  Provides complementary outputs, a one-cycle terminal-count pulse and a sticky
//  overflow flag. Used as the general counter/toggle primitive in sequential blocks.
// PARAMETERS
//  WIDTH      4   counter/register width in bits (>=1)
//  SATURATE   0   0: wrap at limits; 1: clamp at max (up) / 0 (down)
//  RESET_VAL  0   value of q after clear (WIDTH bits)
// PORTS
//  clk      in   1      rising-edge clock
//  clear    in   1      reset, asynchronous, active-high
//  en       in   1      step enable for mode operations
//  mode     in   2      00 hold, 01 toggle, 10 count up, 11 count down
//  t_mask   in   WIDTH  per-bit toggle enables (mode 01 only)
//  load     in   1      synchronous parallel load of d
//  d        in   WIDTH  load data
//  clr_ovf  in   1      synchronous clear of ovf
//  q        out  WIDTH  register value
//  qbar     out  WIDTH  registered complement, always == ~q
//  tc       out  1      terminal-count pulse, one cycle
//  ovf      out  1      sticky overflow/underflow flag
// BEHAVIOUR
//  - Reset (clear=1, async, takes effect immediately, held while high):
//    q=RESET_VAL, qbar=~RESET_VAL, tc=0, ovf=0. Clear mid-count discards the step.
//  - Priority per rising edge: clear > load > (en & mode) > hold.
//  - load=1: q<=d, qbar<=~d, tc<=0; en/mode ignored; ovf unchanged except clr_ovf.
//  - en=0 and load=0: q holds, tc<=0.
//  - mode 00: hold, tc<=0.
//  - mode 01: q<=q^t_mask (each set bit toggles, as a T-FF); tc<=0; no ovf effect.
//  - mode 10: q<=q+1 mod 2^WIDTH. At q=all-ones: SATURATE=0 -> q<=0;
//    SATURATE=1 -> q holds at all-ones. Either case is a limit event.
//  - mode 11: q<=q-1 mod 2^WIDTH. At q=0: SATURATE=0 -> q<=all-ones;
//    SATURATE=1 -> q holds at 0. Either case is a limit event.
//  - Limit event (only with en=1, load=0, mode 1x): tc<=1 for exactly the cycle
//    after that edge; ovf<=1. Consecutive limit events (saturated, en held)
//    keep tc high each cycle.
//  - ovf: sticky; clr_ovf=1 clears it at next edge; a limit event in the same
//    cycle as clr_ovf wins (ovf stays 1).
//  - qbar is a register updated in the same edge as q; q^qbar == all-ones in
//    every cycle, including immediately after reset.
//  - Latency: all outputs registered, one clock from inputs; no combinational
//    input-to-output paths except async clear.
//  - Mode change takes effect on the next edge; no internal state beyond q, qbar, tc, ovf.
// TESTING
//  1 clear=1 mid-run, RESET_VAL=0 -> q=0,qbar=F,tc=0,ovf=0 without waiting for clk.
//  2 WIDTH=4, SATURATE=0, load d=E, en=1 mode=10, 3 edges -> q=F,0,1; tc high
//    only in the cycle q=0; ovf=1 afterwards.
//  3 SATURATE=1, q=1, mode=11, en=1, 3 edges -> q=0,0,0; tc=0,1,1; ovf=1.
//  4 mode=01, q=5, t_mask=3 -> q=6; t_mask=0 -> q=6; t_mask=F -> q=9, qbar=6, tc=0.
//  5 load=1 d=A with en=1 mode=10 same edge -> q=A (load wins); en=0 -> q holds A.
//  6 ovf=1, clr_ovf=1 with wrap event same edge -> ovf stays 1; next edge
//    clr_ovf=1, no event -> ovf=0.

Source files
------------

// File: rtl/tff_updown_counter_if.sv
// Control and status bundle for tff_updown_counter.
// The master drives the step controls and observes the registered outputs;
// the slave (the counter) does the opposite.
interface tff_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t_mask;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clr_ovf;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             ovf;

    modport master (
        output en, mode, t_mask, load, d, clr_ovf,
        input  q, qbar, tc, ovf
    );

    modport slave (
        input  en, mode, t_mask, load, d, clr_ovf,
        output q, qbar, tc, ovf
    );
endinterface

// File: rtl/tff_updown_counter.sv
// Multi-mode register bank: hold, per-bit toggle (T-FF), count up, count down
// and parallel load. qbar is its own register so q ^ qbar is all-ones in every
// cycle. tc pulses in the cycle after a limit event. ovf is sticky.
module tff_updown_counter #(
    parameter int               WIDTH     = 4,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                clk,
    input logic                clear,
    tff_updown_counter_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] q_r, qbar_r, q_next;
    logic             tc_r, ovf_r, ovf_next, limit;

    // Next-state: load beats stepping; a limit is hitting all-ones going up or zero going down.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        q_next   = q_r;
        limit    = 1'b0;
        ovf_next = ovf_r;
        if (bus.load) begin
            q_next = bus.d;
        end else if (bus.en) begin
            case (mode_e'(bus.mode))
                MODE_HOLD:   q_next = q_r;
                MODE_TOGGLE: q_next = q_r ^ bus.t_mask;
                MODE_UP: begin
                    limit  = (q_r == ALL_ONES);
                    q_next = (limit && SATURATE != 0) ? q_r : q_r + ONE;
                end
                MODE_DOWN: begin
                    limit  = (q_r == '0);
                    q_next = (limit && SATURATE != 0) ? q_r : q_r - ONE;
                end
                default:     q_next = q_r;
            endcase
        end
        // A limit event in the same cycle as clr_ovf keeps the flag set.
        if (limit)
            ovf_next = 1'b1;
        else if (bus.clr_ovf)
            ovf_next = 1'b0;
    end

    // State registers; clear acts immediately and holds everything at reset value.
    always_ff @(posedge clk or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (clear) begin
            q_r    <= RESET_VAL;
            qbar_r <= ~RESET_VAL;
            tc_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            q_r    <= q_next;
            qbar_r <= ~q_next;
            tc_r   <= limit;
            ovf_r  <= ovf_next;
        end
    end

    assign bus.q    = q_r;
    assign bus.qbar = qbar_r;
    assign bus.tc   = tc_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Drives a wrapping (u_wrap) and a saturating (u_sat) counter with identical
// stimulus and compares both against an integer-arithmetic reference model.
module tb_tff_updown_counter;

    logic clk = 1'b0;
    logic clear;

    logic       en, load, clr_ovf;
    logic [1:0] mode;
    logic [3:0] t_mask, d;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: index 0 wraps, index 1 saturates.
    int mq[2], mtc[2], movf[2];

    tff_updown_counter_if #(.WIDTH(4)) if_wrap ();
    tff_updown_counter_if #(.WIDTH(4)) if_sat ();

    assign if_wrap.en = en;      assign if_sat.en = en;
    assign if_wrap.mode = mode;  assign if_sat.mode = mode;
    assign if_wrap.t_mask = t_mask; assign if_sat.t_mask = t_mask;
    assign if_wrap.load = load;  assign if_sat.load = load;
    assign if_wrap.d = d;        assign if_sat.d = d;
    assign if_wrap.clr_ovf = clr_ovf; assign if_sat.clr_ovf = clr_ovf;

    tff_updown_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'h0)) u_wrap (
        .clk(clk), .clear(clear), .bus(if_wrap.slave)
    );
    tff_updown_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'h0)) u_sat (
        .clk(clk), .clear(clear), .bus(if_sat.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            mq[s] = 0; mtc[s] = 0; movf[s] = 0;
        end
    endfunction

    // One rising edge of the behavioural model, from the current inputs.
    function automatic void model_edge();
        for (int s = 0; s < 2; s++) begin
            int lim = 0;
            if (load) begin
                mq[s] = int'(d);
            end else if (en && mode == 2'd2) begin
                if (mq[s] == 15) begin lim = 1; mq[s] = (s == 1) ? 15 : 0; end
                else mq[s] = mq[s] + 1;
            end else if (en && mode == 2'd3) begin
                if (mq[s] == 0) begin lim = 1; mq[s] = (s == 1) ? 0 : 15; end
                else mq[s] = mq[s] - 1;
            end else if (en && mode == 2'd1) begin
                mq[s] = mq[s] ^ int'(t_mask);
            end
            mtc[s] = lim;
            if (lim != 0) movf[s] = 1;
            else if (clr_ovf) movf[s] = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_wrap_q"},    32'(if_wrap.q),    32'(mq[0]));
        check({tag, "_wrap_qbar"}, 32'(if_wrap.qbar), 32'((~mq[0]) & 15));
        check({tag, "_wrap_tc"},   32'(if_wrap.tc),   32'(mtc[0]));
        check({tag, "_wrap_ovf"},  32'(if_wrap.ovf),  32'(movf[0]));
        check({tag, "_sat_q"},     32'(if_sat.q),     32'(mq[1]));
        check({tag, "_sat_qbar"},  32'(if_sat.qbar),  32'((~mq[1]) & 15));
        check({tag, "_sat_tc"},    32'(if_sat.tc),    32'(mtc[1]));
        check({tag, "_sat_ovf"},   32'(if_sat.ovf),   32'(movf[1]));
    endtask

    // Advance one clock, update the model, sample 1 time unit after the edge.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic e, input logic [1:0] m, input logic [3:0] tm,
                          input logic l, input logic [3:0] dd, input logic co);
        en = e; mode = m; t_mask = tm; load = l; d = dd; clr_ovf = co;
    endtask

    // Asynchronous clear between edges, held across one edge, then released.
    task automatic pulse_clear(input string tag);
        clear = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1;
        set_in(1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 1'b0);
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_held");
        clear = 1'b0;

        // Wrap upward from E: q=F, 0, 1; tc only in the cycle q=0; ovf set.
        set_in(1'b0, 2'd0, 4'h0, 1'b1, 4'hE, 1'b0); step("t2_load");
        set_in(1'b1, 2'd2, 4'h0, 1'b0, 4'h0, 1'b0); step("t2_e1");
        check("t2_q_F", 32'(if_wrap.q), 32'hF);
        check("t2_tc_0", 32'(if_wrap.tc), 32'h0);
        step("t2_e2");
        check("t2_q_0", 32'(if_wrap.q), 32'h0);
        check("t2_tc_1", 32'(if_wrap.tc), 32'h1);
        check("t2_sat_hold_F", 32'(if_sat.q), 32'hF);
        step("t2_e3");
        check("t2_q_1", 32'(if_wrap.q), 32'h1);
        check("t2_tc_done", 32'(if_wrap.tc), 32'h0);
        check("t2_ovf", 32'(if_wrap.ovf), 32'h1);

        // clr_ovf coinciding with a wrap keeps ovf; a later clr_ovf alone clears it.
        set_in(1'b0, 2'd0, 4'h0, 1'b1, 4'hF, 1'b0); step("t6_load");
        set_in(1'b1, 2'd2, 4'h0, 1'b0, 4'h0, 1'b1); step("t6_wrap_clr");
        check("t6_ovf_kept", 32'(if_wrap.ovf), 32'h1);
        set_in(1'b0, 2'd2, 4'h0, 1'b0, 4'h0, 1'b1); step("t6_clr");
        check("t6_ovf_cleared", 32'(if_wrap.ovf), 32'h0);

        // Clear mid-count, with ovf set beforehand.
        set_in(1'b1, 2'd3, 4'h0, 1'b0, 4'h0, 1'b0); step("t1_run0"); step("t1_run1");
        clear = 1'b1;
        #1;
        check("t1_q", 32'(if_wrap.q), 32'h0);
        check("t1_qbar", 32'(if_wrap.qbar), 32'hF);
        check("t1_tc", 32'(if_wrap.tc), 32'h0);
        check("t1_ovf", 32'(if_wrap.ovf), 32'h0);
        clear = 1'b0;
        pulse_clear("t1");

        // Saturating down from 1: q=0,0,0; tc=0,1,1; ovf=1.
        set_in(1'b0, 2'd0, 4'h0, 1'b1, 4'h1, 1'b0); step("t3_load");
        set_in(1'b1, 2'd3, 4'h0, 1'b0, 4'h0, 1'b0);
        step("t3_e1");
        check("t3_q1", 32'(if_sat.q), 32'h0);
        check("t3_tc1", 32'(if_sat.tc), 32'h0);
        step("t3_e2");
        check("t3_q2", 32'(if_sat.q), 32'h0);
        check("t3_tc2", 32'(if_sat.tc), 32'h1);
        step("t3_e3");
        check("t3_q3", 32'(if_sat.q), 32'h0);
        check("t3_tc3", 32'(if_sat.tc), 32'h1);
        check("t3_ovf", 32'(if_sat.ovf), 32'h1);

        // Toggle mode from 5.
        set_in(1'b0, 2'd0, 4'h0, 1'b1, 4'h5, 1'b0); step("t4_load");
        set_in(1'b1, 2'd1, 4'h3, 1'b0, 4'h0, 1'b0); step("t4_m3");
        check("t4_q6", 32'(if_wrap.q), 32'h6);
        set_in(1'b1, 2'd1, 4'h0, 1'b0, 4'h0, 1'b0); step("t4_m0");
        check("t4_q6_hold", 32'(if_wrap.q), 32'h6);
        set_in(1'b1, 2'd1, 4'hF, 1'b0, 4'h0, 1'b0); step("t4_mF");
        check("t4_q9", 32'(if_wrap.q), 32'h9);
        check("t4_qbar6", 32'(if_wrap.qbar), 32'h6);
        check("t4_tc0", 32'(if_wrap.tc), 32'h0);

        // Load beats counting; en=0 holds.
        set_in(1'b1, 2'd2, 4'h0, 1'b1, 4'hA, 1'b0); step("t5_load");
        check("t5_qA", 32'(if_wrap.q), 32'hA);
        set_in(1'b0, 2'd2, 4'h0, 1'b0, 4'h0, 1'b0); step("t5_hold");
        check("t5_qA_hold", 32'(if_wrap.q), 32'hA);

        // Randomised traffic, with occasional asynchronous clears.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 4) != 0, 2'($urandom % 4), 4'($urandom % 16),
                   ($urandom % 8) == 0, 4'($urandom % 16), ($urandom % 8) == 0);
            if (($urandom % 60) == 0)
                pulse_clear("rnd_clr");
            else
                step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
